// File: rtl/sensor_i2c_pkg.sv
// Shared types and constants for the sensor-side I2C read path: arbiter state
// encoding, bus field widths and TCS34725 colour-sensor register addresses.
package sensor_i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int REG_ADDR_W = 8;
    localparam int DATA_W     = 16;

    localparam logic [I2C_ADDR_W-1:0] TCS34725_ADDR   = 7'h29;
    localparam logic [REG_ADDR_W-1:0] TCS34725_RDATAL = 8'h16;
    localparam logic [REG_ADDR_W-1:0] TCS34725_GDATAL = 8'h18;
    localparam logic [REG_ADDR_W-1:0] TCS34725_BDATAL = 8'h1A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-priority encoder: returns the first set request at or
// above rr_ptr, wrapping modulo NUM_REQ.
module rr_priority_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    int               idx;
    logic [IDX_W-1:0] sel;

    // Walk priorities from lowest to highest so the closest request to rr_ptr wins last.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IDX_W'(idx);
            if (req[sel]) begin
                grant_idx = sel;
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_read_arbiter.sv
// Round-robin arbiter sharing one 2-byte-read I2C master among NUM_REQ sensor FSMs.
// Optional WAIT-state timeout with abort/RECOVER is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_read_arbiter
    import sensor_i2c_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_dev_addr,
    input  logic [REG_ADDR_W*NUM_REQ-1:0] req_reg_addr,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [DATA_W-1:0]             req_data,
    output logic                          start_i2c,
    output logic [I2C_ADDR_W-1:0]         dev_addr,
    output logic [REG_ADDR_W-1:0]         reg_addr,
    input  logic                          busy_i2c,
    input  logic                          done_i2c,
    input  logic [DATA_W-1:0]             data_in
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [I2C_ADDR_W-1:0]  dev_addr_q, dev_addr_d;
    logic [REG_ADDR_W-1:0]  reg_addr_q, reg_addr_d;
    logic                   start_q, start_d;
    logic [NUM_REQ-1:0]     ack_q, ack_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [DATA_W-1:0]      data_q, data_d;
`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0]            cnt_q, cnt_d;
    logic [NUM_REQ-1:0]     err_q, err_d;
`endif

    logic [IDX_W-1:0]       grant_idx;
    logic                   any_req;
    logic [IDX_W-1:0]       next_ptr;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign next_ptr = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        dev_addr_d = dev_addr_q;
        reg_addr_d = reg_addr_q;
        start_d    = 1'b0;
        ack_d      = '0;
        done_d     = '0;
        data_d     = data_q;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req && !busy_i2c) begin
                    owner_d          = grant_idx;
                    dev_addr_d       = req_dev_addr[int'(grant_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                    reg_addr_d       = req_reg_addr[int'(grant_idx)*REG_ADDR_W +: REG_ADDR_W];
                    start_d          = 1'b1;
                    ack_d[grant_idx] = 1'b1;
                    state_d          = ST_ISSUE;
                end
            end
            // The master only sees start this cycle, so any done_i2c here is stale.
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                if (done_i2c) begin
                    data_d          = data_in;
                    done_d[owner_q] = 1'b1;
                    rr_ptr_d        = next_ptr;
                    state_d         = ST_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    data_d          = '0;
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = 1'b1;
                    rr_ptr_d        = next_ptr;
                    state_d         = ST_RECOVER;
                end else begin
                    cnt_d = cnt_q + 32'd1;
`endif
                end
            end
`ifdef I2C_ARB_TIMEOUT_EN
            ST_RECOVER: begin
                if (!busy_i2c) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            dev_addr_q <= '0;
            reg_addr_q <= '0;
            start_q    <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
            data_q     <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            dev_addr_q <= dev_addr_d;
            reg_addr_q <= reg_addr_d;
            start_q    <= start_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            data_q     <= data_d;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign start_i2c = start_q;
    assign dev_addr  = dev_addr_q;
    assign reg_addr  = reg_addr_q;
    assign req_ack   = ack_q;
    assign req_done  = done_q;
    assign req_data  = data_q;
`ifdef I2C_ARB_TIMEOUT_EN
    assign req_err   = err_q;
`else
    assign req_err   = '0;
`endif

endmodule
